brick_map_ctrl: RTL and testbench

Owns the 8×12 brick-alive map for the breakout playfield. It sequences level loading, serialises brick-hit requests from the ball collision logic, and serves a one-cycle-latency lookup port to the renderer. The collision and render paths supply grid coordinates (bx 0–7, by 0–11), which come from the existing screen-to-grid finder. It also maintains the bricks-remaining count and the score.

---
 rtl/brick_map_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_brick_map_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/brick_map_ctrl.sv
// Brick-alive map for the breakout playfield: level loading, serialised brick hits,
// registered renderer lookup, bricks-remaining count and saturating score.
module brick_map_ctrl #(
    parameter int COLS = 8,
    parameter int ROWS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [1:0]  pattern_i,
    output logic        busy_o,
    input  logic        hit_req_i,
    input  logic [3:0]  hit_bx_i,
    input  logic [3:0]  hit_by_i,
    output logic        hit_ack_o,
    output logic        hit_was_brick_o,
    input  logic [3:0]  rd_bx_i,
    input  logic [3:0]  rd_by_i,
    output logic        rd_alive_o,
    output logic [6:0]  bricks_left_o,
    output logic        cleared_o,
    output logic [15:0] score_o
);

    localparam int         CELLS    = COLS * ROWS;
    localparam logic [6:0] LAST_IDX = 7'(CELLS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] HIT  = 2'd2;
    localparam logic [1:0] REL  = 2'd3;

    function automatic logic [6:0] lin_idx(input logic [3:0] bx, input logic [3:0] by);
        return 7'({3'b000, by} * 7'(COLS) + {3'b000, bx});
    endfunction

    function automatic logic in_grid(input logic [3:0] bx, input logic [3:0] by);
        return (bx < 4'(COLS)) && (by < 4'(ROWS));
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CELLS-1:0] cells_q;
    logic [6:0]       idx_q, idx_d;
    logic [3:0]       ld_bx_q, ld_bx_d;
    logic [3:0]       ld_by_q, ld_by_d;
    logic [1:0]       pattern_q, pattern_d;
    logic [6:0]       bricks_q, bricks_d;
    logic [15:0]      score_q, score_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             was_q, was_d;
    logic             cleared_q, cleared_d;
    logic [6:0]       hit_idx_q, hit_idx_d;
    logic [3:0]       hit_pts_q, hit_pts_d;
    logic             rd_alive_q, rd_alive_d;

    logic             load_val;
    logic             hit_live;
    logic [16:0]      score_sum;

    always_comb begin
        load_val = 1'b1;
        case (pattern_q)
            2'd0:    load_val = 1'b1;
            2'd1:    load_val = ~(ld_bx_q[0] ^ ld_by_q[0]);
            2'd2:    load_val = (ld_by_q < 4'(ROWS / 2));
            default: load_val = ~ld_by_q[0];
        endcase
    end

    assign hit_live  = in_grid(hit_bx_i, hit_by_i) && cells_q[lin_idx(hit_bx_i, hit_by_i)];
    assign score_sum = {1'b0, score_q} + 17'(hit_pts_q);
    assign rd_alive_d = in_grid(rd_bx_i, rd_by_i) && cells_q[lin_idx(rd_bx_i, rd_by_i)];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ld_bx_d   = ld_bx_q;
        ld_by_d   = ld_by_q;
        pattern_d = pattern_q;
        bricks_d  = bricks_q;
        score_d   = score_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        was_d     = 1'b0;
        cleared_d = 1'b0;
        hit_idx_d = hit_idx_q;
        hit_pts_d = hit_pts_q;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d   = LOAD;
                    pattern_d = pattern_i;
                    idx_d     = '0;
                    ld_bx_d   = '0;
                    ld_by_d   = '0;
                    bricks_d  = '0;
                    busy_d    = 1'b1;
                end else if (hit_req_i) begin
                    // Decide the outcome now so ack, was_brick and cleared appear together.
                    state_d   = HIT;
                    ack_d     = 1'b1;
                    was_d     = hit_live;
                    cleared_d = hit_live && (bricks_q == 7'd1);
                    hit_idx_d = lin_idx(hit_bx_i, hit_by_i);
                    hit_pts_d = 4'(ROWS) - hit_by_i;
                end
            end
            LOAD: begin
                if (load_val) begin
                    bricks_d = bricks_q + 7'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    idx_d = idx_q + 7'd1;
                    if (ld_bx_q == 4'(COLS - 1)) begin
                        ld_bx_d = '0;
                        ld_by_d = ld_by_q + 4'd1;
                    end else begin
                        ld_bx_d = ld_bx_q + 4'd1;
                    end
                end
            end
            HIT: begin
                if (was_q) begin
                    bricks_d = bricks_q - 7'd1;
                    score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                end
                state_d = REL;
            end
            default: begin
                if (!hit_req_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells_q <= '0;
        end else if (state_q == LOAD) begin
            cells_q[idx_q] <= load_val;
        end else if ((state_q == HIT) && was_q) begin
            cells_q[hit_idx_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ld_bx_q    <= '0;
            ld_by_q    <= '0;
            pattern_q  <= '0;
            bricks_q   <= '0;
            score_q    <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            was_q      <= 1'b0;
            cleared_q  <= 1'b0;
            hit_idx_q  <= '0;
            hit_pts_q  <= '0;
            rd_alive_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ld_bx_q    <= ld_bx_d;
            ld_by_q    <= ld_by_d;
            pattern_q  <= pattern_d;
            bricks_q   <= bricks_d;
            score_q    <= score_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            was_q      <= was_d;
            cleared_q  <= cleared_d;
            hit_idx_q  <= hit_idx_d;
            hit_pts_q  <= hit_pts_d;
            rd_alive_q <= rd_alive_d;
        end
    end

    assign busy_o          = busy_q;
    assign hit_ack_o       = ack_q;
    assign hit_was_brick_o = was_q;
    assign rd_alive_o      = rd_alive_q;
    assign bricks_left_o   = bricks_q;
    assign cleared_o       = cleared_q;
    assign score_o         = score_q;

endmodule

// File: tb/tb_brick_map_ctrl.sv
// Directed bench for brick_map_ctrl: loads, hits, handshake timing, read-port and reset abort.
module tb_brick_map_ctrl;

    logic        clk;
    logic        rst;
    logic        load_i;
    logic [1:0]  pattern_i;
    logic        busy_o;
    logic        hit_req_i;
    logic [3:0]  hit_bx_i;
    logic [3:0]  hit_by_i;
    logic        hit_ack_o;
    logic        hit_was_brick_o;
    logic [3:0]  rd_bx_i;
    logic [3:0]  rd_by_i;
    logic        rd_alive_o;
    logic [6:0]  bricks_left_o;
    logic        cleared_o;
    logic [15:0] score_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_score = 0;
    int exp_bricks = 0;
    int clr_count = 0;

    brick_map_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .load_i          (load_i),
        .pattern_i       (pattern_i),
        .busy_o          (busy_o),
        .hit_req_i       (hit_req_i),
        .hit_bx_i        (hit_bx_i),
        .hit_by_i        (hit_by_i),
        .hit_ack_o       (hit_ack_o),
        .hit_was_brick_o (hit_was_brick_o),
        .rd_bx_i         (rd_bx_i),
        .rd_by_i         (rd_by_i),
        .rd_alive_o      (rd_alive_o),
        .bricks_left_o   (bricks_left_o),
        .cleared_o       (cleared_o),
        .score_o         (score_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts a load and counts busy cycles; inputs change only on falling edges.
    task automatic do_load(input logic [1:0] pat, input int exp_cnt);
        int cnt;
        load_i    = 1'b1;
        pattern_i = pat;
        @(negedge clk);
        load_i = 1'b0;
        cnt = 0;
        while (busy_o && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("load_busy_cycles", cnt, 96);
        check("load_bricks_left", bricks_left_o, exp_cnt);
        $display("load pattern=%0d busy_cycles=%0d bricks_left=%0d", pat, cnt, bricks_left_o);
    endtask

    task automatic do_read(input logic [3:0] bx, input logic [3:0] by, input logic exp);
        rd_bx_i = bx;
        rd_by_i = by;
        @(negedge clk);
        check("rd_alive", rd_alive_o, exp);
        $display("read (%0d,%0d) alive=%0d", bx, by, rd_alive_o);
    endtask

    // Waits for ack with hit_req already high, then completes the 4-phase handshake.
    task automatic finish_hit(input logic exp_was, input logic exp_clr);
        int cnt;
        cnt = 0;
        while (!hit_ack_o && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("hit_ack_seen", hit_ack_o, 1);
        check("hit_was_brick", hit_was_brick_o, exp_was);
        check("hit_cleared", cleared_o, exp_clr);
        if (cleared_o) clr_count++;
        if (exp_was) begin
            exp_bricks = exp_bricks - 1;
            exp_score  = exp_score + (12 - int'(hit_by_i));
        end
        $display("hit (%0d,%0d) was_brick=%0d cleared=%0d", hit_bx_i, hit_by_i, hit_was_brick_o, cleared_o);
        hit_req_i = 1'b0;
        @(negedge clk);
        check("hit_ack_one_cycle", hit_ack_o, 0);
        check("hit_bricks_left", bricks_left_o, exp_bricks);
        check("hit_score", score_o, exp_score);
        check("rd_pre_clear", rd_alive_o, exp_was);
        @(negedge clk);
        check("rd_post_clear", rd_alive_o, 0);
    endtask

    task automatic do_hit(input logic [3:0] bx, input logic [3:0] by,
                          input logic exp_was, input logic exp_clr);
        hit_bx_i  = bx;
        hit_by_i  = by;
        rd_bx_i   = bx;
        rd_by_i   = by;
        hit_req_i = 1'b1;
        @(negedge clk);
        finish_hit(exp_was, exp_clr);
    endtask

    initial begin
        int lo;
        int cnt;
        rst       = 1'b1;
        load_i    = 1'b0;
        pattern_i = 2'd0;
        hit_req_i = 1'b0;
        hit_bx_i  = 4'd0;
        hit_by_i  = 4'd0;
        rd_bx_i   = 4'd0;
        rd_by_i   = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_ack", hit_ack_o, 0);
        check("rst_bricks", bricks_left_o, 0);
        check("rst_score", score_o, 0);
        check("rst_rd_alive", rd_alive_o, 0);
        check("rst_cleared", cleared_o, 0);
        rst = 1'b0;
        @(negedge clk);

        do_load(2'd0, 96);
        exp_bricks = 96;
        do_read(4'd0, 4'd0, 1'b1);
        do_read(4'd7, 4'd11, 1'b1);
        do_read(4'd8, 4'd0, 1'b0);

        do_hit(4'd2, 4'd0, 1'b1, 1'b0);
        do_hit(4'd2, 4'd0, 1'b0, 1'b0);
        do_hit(4'd8, 4'd3, 1'b0, 1'b0);
        do_hit(4'd0, 4'd12, 1'b0, 1'b0);

        do_load(2'd1, 48);
        do_read(4'd1, 4'd0, 1'b0);
        do_read(4'd1, 4'd1, 1'b1);
        do_load(2'd3, 48);
        do_read(4'd3, 4'd1, 1'b0);
        do_read(4'd3, 4'd2, 1'b1);

        // Hit raised mid-load must wait until busy falls, then be acked one cycle later.
        load_i    = 1'b1;
        pattern_i = 2'd0;
        @(negedge clk);
        load_i = 1'b0;
        repeat (10) @(negedge clk);
        hit_bx_i  = 4'd3;
        hit_by_i  = 4'd5;
        rd_bx_i   = 4'd3;
        rd_by_i   = 4'd5;
        hit_req_i = 1'b1;
        lo  = 0;
        cnt = 0;
        while (!hit_ack_o && cnt < 300) begin
            if (busy_o) lo = 0;
            else lo++;
            @(negedge clk);
            cnt++;
        end
        check("load_hit_busy_at_ack", busy_o, 0);
        check("load_hit_gap", lo, 1);
        exp_bricks = 96;
        finish_hit(1'b1, 1'b0);

        do_load(2'd2, 48);
        exp_bricks = 48;
        clr_count  = 0;
        for (int by = 0; by < 6; by++) begin
            for (int bx = 0; bx < 8; bx++) begin
                do_hit(4'(bx), 4'(by), 1'b1, (by == 5 && bx == 7));
            end
        end
        check("clear_pulse_count", clr_count, 1);
        check("clear_bricks_zero", bricks_left_o, 0);
        check("clear_score_total", score_o, 12 + 7 + 456);
        do_hit(4'd0, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-load at idx 40.
        load_i    = 1'b1;
        pattern_i = 2'd0;
        @(negedge clk);
        load_i = 1'b0;
        repeat (40) @(negedge clk);
        check("pre_abort_busy", busy_o, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy_o, 0);
        check("abort_bricks", bricks_left_o, 0);
        check("abort_score", score_o, 0);
        check("abort_ack", hit_ack_o, 0);
        check("abort_rd_alive", rd_alive_o, 0);
        $display("reset asserted mid-load busy=%0d bricks_left=%0d", busy_o, bricks_left_o);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_load(2'd0, 96);
        check("post_abort_score", score_o, 0);
        do_read(4'd5, 4'd5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
